mcyc_sequencer: RTL
===================

# mcyc_sequencer

Multi-cycle sequencer for the single-bus MIPS datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and issues the per-phase write enables, mux selects and memory requests. The combinational instruction decoder classifies the instruction; this block owns the phase state, the memory wait handshakes and the illegal-opcode trap. It sits between the datapath registers (PC, IR, register file, data memory port) and the instruction/data memory interfaces.

## Interface
- `i_clk  in  1`: system clock; all state updates on the rising edge.
- `i_rst_n  in  1`: reset, asynchronous, active-low.
- `i_mcyc_opcode  in  6`: IR[31:26]; valid from DECODE onward.
- `i_mcyc_funct  in  6`: IR[5:0]; valid from DECODE onward.
- `i_mcyc_zero  in  1`: ALU zero flag; sampled in EXEC for branches.
- `i_mcyc_iMemReady  in  1`: instruction memory has data for the current request.
- `i_mcyc_dMemReady  in  1`: data memory access completes this cycle.
- `o_mcyc_iMemReq  out  1`: instruction fetch request.
- `o_mcyc_dMemReq  out  1`: data memory request.
- `o_mcyc_dMemWe  out  1`: data memory write (sw).
- `o_mcyc_irWe  out  1`: load the IR.
- `o_mcyc_pcWe  out  1`: load the PC.
- `o_mcyc_pcSrc  out  2`: PC source. 0 = PC+4, 1 = branch target, 2 = jump target.
- `o_mcyc_regWe  out  1`: register file write.
- `o_mcyc_regDst  out  1`: destination register. 1 = rd, 0 = rt.
- `o_mcyc_memToReg  out  1`: writeback data source. 1 = load data, 0 = ALU result.
- `o_mcyc_aluSrcB  out  1`: ALU B operand. 1 = extended immediate, 0 = rt.
- `o_mcyc_state  out  3`: current phase encoding, for debug.
- `o_mcyc_retire  out  1`: one-cycle pulse when an instruction completes.
- `o_mcyc_trap  out  1`: illegal instruction; stays high until reset.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Instruction classes, latched into an internal class register on exit from DECODE:
  - RALU: opcode 000000 with funct in {100000, 100001, 100010, 100011, 100100, 100101, 100110, 100111, 101010}.
  - IALU: opcodes 001000, 001001, 001100, 001101, 001110, 001111.
  - LOAD: 100011.
  - STORE: 101011.
  - BR: 000100 (beq), 000101 (bne).
  - JMP: 000010.
  - Any other encoding is ILL.
- FETCH:
  - Drive iMemReq=1.
  - When iMemReady=1: irWe=1, pcWe=1, pcSrc=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Latch the class.
  - ILL goes to TRAP; every other class goes to EXEC.
- EXEC:
  - aluSrcB=1 for IALU, LOAD and STORE.
  - BR: pcSrc=1; pcWe = zero for beq, ~zero for bne; retire=1; go to FETCH.
  - JMP: pcSrc=2, pcWe=1, retire=1; go to FETCH.
  - LOAD and STORE go to MEM; RALU and IALU go to WB.
- MEM:
  - Drive dMemReq=1; dMemWe=1 only for STORE.
  - Advance only on dMemReady.
  - STORE: retire=1, then FETCH.
  - LOAD: go to WB.
- WB:
  - regWe=1, retire=1.
  - regDst=1 only for RALU; memToReg=1 only for LOAD.
  - Go to FETCH.
- TRAP: all enables and requests 0, trap=1. TRAP is absorbing; only reset leaves it.
- All outputs are Moore decodes of {state, class, ready/zero inputs}. No output is registered except state and class.

## Timing
- Reset (asynchronous assert, synchronous release): state=FETCH, class=RALU.
- Outputs during reset: iMemReq=1; every other output 0; o_mcyc_state=0.
- Cycle counts with zero wait states:
  - BR and JMP: 3 cycles.
  - RALU, IALU and STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each cycle a ready input is low adds one cycle to FETCH or MEM.
- Requests hold high until ready. A ready input outside its requesting state is ignored.
- Opcode and funct are sampled only in DECODE; later IR changes do not affect the latched class.
- Reset asserted mid-instruction aborts it immediately: no retire and no write enables.

## Configuration
- `MCYC_MEM_HANDSHAKE_EN` defined: behaviour as above; FETCH and MEM wait for their ready input.
- Not defined:
  - Both ready inputs are ignored and treated as 1, so every memory phase takes exactly one cycle.
  - iMemReq and dMemReq are still driven as specified.

## Structure
- Package `mcyc_pkg` holds:
  - the state enum and the class enum;
  - the opcode and funct localparams;
  - the pcSrc encodings.
- Sub-module `mcyc_decode` (combinational): {opcode, funct} → class.
- `mcyc_sequencer` contains the state register, the class register and the output decode.

## Test plan
- Reset release, then `addi` (0x2008_0005) with ready held at 1:
  - sequence FETCH→DECODE→EXEC→WB;
  - regWe=1 with regDst=0 in the WB cycle;
  - retire pulses once, on cycle 4.
- `lw` with dMemReady low for 3 cycles (macro defined):
  - MEM is held for 4 cycles;
  - dMemReq stays high throughout with dMemWe=0;
  - total 8 cycles to retire.
- `beq` with zero=1, then `bne` with zero=1:
  - first: pcWe=1 and pcSrc=1 in EXEC;
  - second: pcWe=0;
  - both retire after 3 cycles.
- Opcode 0x3F:
  - DECODE→TRAP, trap=1;
  - iMemReq stays 0 for 20 cycles;
  - i_rst_n low returns to FETCH with trap=0.
- Reset asserted during MEM of a `sw`:
  - dMemWe drops asynchronously;
  - no retire;
  - state=FETCH.
- Macro undefined with iMemReady tied to 0: `j` still completes in 3 cycles.

Source files
------------

// File: rtl/mcyc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencer.
// The optional memory handshake is enabled with MCYC_MEM_HANDSHAKE_EN.
package mcyc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned PCSRC_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_RALU  = 3'd0,
    CLS_IALU  = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_BR    = 3'd4,
    CLS_JMP   = 3'd5,
    CLS_ILL   = 3'd6
  } class_e;

  // Instruction class plus the beq/bne polarity, latched together out of DECODE.
  typedef struct packed {
    class_e kind;
    logic   br_ne;
  } cls_t;

  // Per-cycle control bundle produced by the phase decode.
  typedef struct packed {
    logic               imem_req;
    logic               dmem_req;
    logic               dmem_we;
    logic               ir_we;
    logic               pc_we;
    logic [PCSRC_W-1:0] pc_src;
    logic               reg_we;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_b;
    logic               retire;
    logic               trap;
  } ctrl_t;

  localparam logic [PCSRC_W-1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'd2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'b101010;

  // True for the R-type funct codes the datapath ALU implements.
  function automatic logic is_ralu_funct(input logic [FUNCT_W-1:0] funct);
    logic hit;
    hit = 1'b0;
    case (funct)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mcyc_decode.sv
// Combinational instruction classifier: {opcode, funct} -> class.
// Used by mcyc_sequencer; independent of MCYC_MEM_HANDSHAKE_EN.
module mcyc_decode
  import mcyc_pkg::*;
(
  input  logic [OP_W-1:0]    opcode_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output cls_t               cls_o
);

  always_comb begin
    cls_o.kind  = CLS_ILL;
    cls_o.br_ne = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        if (is_ralu_funct(funct_i)) begin
          cls_o.kind = CLS_RALU;
        end
      end
      OP_ADDI, OP_ADDIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI: cls_o.kind = CLS_IALU;
      OP_LW:                   cls_o.kind = CLS_LOAD;
      OP_SW:                   cls_o.kind = CLS_STORE;
      OP_BEQ:                  cls_o.kind = CLS_BR;
      OP_BNE: begin
        cls_o.kind  = CLS_BR;
        cls_o.br_ne = 1'b1;
      end
      OP_J:                    cls_o.kind = CLS_JMP;
      default:                 cls_o.kind = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mcyc_sequencer.sv
// Phase sequencer for the multi-cycle MIPS datapath (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define MCYC_MEM_HANDSHAKE_EN to make FETCH and MEM wait on their ready inputs.
module mcyc_sequencer
  import mcyc_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [OP_W-1:0]    i_mcyc_opcode,
  input  logic [FUNCT_W-1:0] i_mcyc_funct,
  input  logic               i_mcyc_zero,
  input  logic               i_mcyc_iMemReady,
  input  logic               i_mcyc_dMemReady,
  output logic               o_mcyc_iMemReq,
  output logic               o_mcyc_dMemReq,
  output logic               o_mcyc_dMemWe,
  output logic               o_mcyc_irWe,
  output logic               o_mcyc_pcWe,
  output logic [PCSRC_W-1:0] o_mcyc_pcSrc,
  output logic               o_mcyc_regWe,
  output logic               o_mcyc_regDst,
  output logic               o_mcyc_memToReg,
  output logic               o_mcyc_aluSrcB,
  output logic [STATE_W-1:0] o_mcyc_state,
  output logic               o_mcyc_retire,
  output logic               o_mcyc_trap
);

  state_e state_q, state_d;
  cls_t   cls_q, cls_d;
  cls_t   dec_cls;
  ctrl_t  ctrl;
  logic   imem_rdy;
  logic   dmem_rdy;

  mcyc_decode u_decode (
    .opcode_i (i_mcyc_opcode),
    .funct_i  (i_mcyc_funct),
    .cls_o    (dec_cls)
  );

`ifdef MCYC_MEM_HANDSHAKE_EN
  assign imem_rdy = i_mcyc_iMemReady;
  assign dmem_rdy = i_mcyc_dMemReady;
`else
  // Without the handshake every memory phase completes in one cycle.
  logic unused_rdy;
  assign unused_rdy = i_mcyc_iMemReady ^ i_mcyc_dMemReady;
  assign imem_rdy   = 1'b1;
  assign dmem_rdy   = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_FETCH;
      cls_q.kind  <= CLS_RALU;
      cls_q.br_ne <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next-state and Moore control decode.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    ctrl    = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.imem_req = 1'b1;
        if (imem_rdy) begin
          ctrl.ir_we  = 1'b1;
          ctrl.pc_we  = 1'b1;
          ctrl.pc_src = PCSRC_SEQ;
          state_d     = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cls_d   = dec_cls;
        state_d = (dec_cls.kind == CLS_ILL) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        ctrl.alu_src_b = (cls_q.kind == CLS_IALU) || (cls_q.kind == CLS_LOAD) ||
                         (cls_q.kind == CLS_STORE);
        case (cls_q.kind)
          CLS_BR: begin
            ctrl.pc_src = PCSRC_BRANCH;
            ctrl.pc_we  = i_mcyc_zero ^ cls_q.br_ne;
            ctrl.retire = 1'b1;
            state_d     = ST_FETCH;
          end
          CLS_JMP: begin
            ctrl.pc_src = PCSRC_JUMP;
            ctrl.pc_we  = 1'b1;
            ctrl.retire = 1'b1;
            state_d     = ST_FETCH;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_RALU, CLS_IALU:  state_d = ST_WB;
          default:             state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        ctrl.dmem_req = 1'b1;
        ctrl.dmem_we  = (cls_q.kind == CLS_STORE);
        if (dmem_rdy) begin
          if (cls_q.kind == CLS_STORE) begin
            ctrl.retire = 1'b1;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.retire     = 1'b1;
        ctrl.reg_dst    = (cls_q.kind == CLS_RALU);
        ctrl.mem_to_reg = (cls_q.kind == CLS_LOAD);
        state_d         = ST_FETCH;
      end
      ST_TRAP: begin
        ctrl.trap = 1'b1;
        state_d   = ST_TRAP;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Enables are masked by reset so an aborted instruction never writes or retires.
  assign o_mcyc_iMemReq  = ctrl.imem_req;
  assign o_mcyc_dMemReq  = ctrl.dmem_req & i_rst_n;
  assign o_mcyc_dMemWe   = ctrl.dmem_we & i_rst_n;
  assign o_mcyc_irWe     = ctrl.ir_we & i_rst_n;
  assign o_mcyc_pcWe     = ctrl.pc_we & i_rst_n;
  assign o_mcyc_pcSrc    = ctrl.pc_src & {PCSRC_W{i_rst_n}};
  assign o_mcyc_regWe    = ctrl.reg_we & i_rst_n;
  assign o_mcyc_regDst   = ctrl.reg_dst & i_rst_n;
  assign o_mcyc_memToReg = ctrl.mem_to_reg & i_rst_n;
  assign o_mcyc_aluSrcB  = ctrl.alu_src_b & i_rst_n;
  assign o_mcyc_retire   = ctrl.retire & i_rst_n;
  assign o_mcyc_trap     = ctrl.trap & i_rst_n;
  assign o_mcyc_state    = STATE_W'(state_q);

endmodule
